// File: rtl/hamming_stream_ctrl_if.sv
// Operand/result handshake bundle between a stream source, the Hamming
// stream controller and its external accumulator.
//   start, in_valid, in_x, in_y, in_ready  : run request and operand beats
//   x, y, acc_clr, acc_o                   : accumulator drive and running sum
//   result, result_valid, result_ready     : final-distance handshake
//   busy                                   : controller not idle
interface hamming_stream_ctrl_if #(
    parameter int unsigned W  = 5,
    parameter int unsigned OW = 11
);
    logic          start;
    logic          in_valid;
    logic [W-1:0]  in_x;
    logic [W-1:0]  in_y;
    logic          in_ready;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          acc_clr;
    logic [OW-1:0] acc_o;
    logic [OW-1:0] result;
    logic          result_valid;
    logic          result_ready;
    logic          busy;

    // Environment side: stream source, accumulator and result sink.
    modport master (
        output start, in_valid, in_x, in_y, acc_o, result_ready,
        input  in_ready, x, y, acc_clr, result, result_valid, busy
    );

    // Controller side.
    modport slave (
        input  start, in_valid, in_x, in_y, acc_o, result_ready,
        output in_ready, x, y, acc_clr, result, result_valid, busy
    );
endinterface

// File: rtl/hamming_stream_ctrl.sv
// Hamming-distance stream controller: accepts CC operand chunks of W bits,
// forwards each (or zero on bubbles) to an external accumulator, captures the
// accumulator's running sum after the last chunk and holds it until taken.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : handshake bundle (slave modport), see hamming_stream_ctrl_if
module hamming_stream_ctrl #(
    parameter int unsigned N  = 1600,
    parameter int unsigned CC = 320,
    parameter int unsigned OW = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    hamming_stream_ctrl_if.slave   bus
);
    localparam int unsigned W  = N / CC;
    localparam int unsigned CW = $clog2(CC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [OW-1:0]   r_result;
    logic            r_result_valid;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_acc_clr;
    logic            w_beat;

    // in_ready is only ever high in STREAM, so this also gates data outside it.
    assign w_beat = r_in_ready & bus.in_valid;

    // Controller FSM with all outputs held in flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_in_ready     <= 1'b0;
            r_busy         <= 1'b0;
            r_acc_clr      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_x <= '0;
                    r_y <= '0;
                    if (bus.start) begin
                        r_state    <= STREAM;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_acc_clr  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (w_beat) begin
                        r_x   <= bus.in_x;
                        r_y   <= bus.in_y;
                        r_cnt <= r_cnt + CW'(1);
                        // Drop ready on the edge taking the final beat.
                        if (r_cnt == CW'(CC - 1)) begin
                            r_state    <= DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end else begin
                        // Bubble: zero chunk adds zero distance.
                        r_x <= '0;
                        r_y <= '0;
                    end
                end
                DRAIN: begin
                    // acc_o now includes the last chunk still on x/y.
                    r_result <= bus.acc_o;
                    r_x      <= '0;
                    r_y      <= '0;
                    r_state  <= HOLD;
                end
                HOLD: begin
                    // Valid rises one edge after capture; result is already stable.
                    if (!r_result_valid) begin
                        r_result_valid <= 1'b1;
                    end else if (bus.result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_acc_clr      <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.x            = r_x;
    assign bus.y            = r_y;
    assign bus.acc_clr      = r_acc_clr;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_hamming_stream_ctrl.sv
// Bench for hamming_stream_ctrl paired with a behavioural 1600-bit/320-beat
// Hamming accumulator; expected distances are queued at stimulus time.
module tb_hamming_stream_ctrl;
    localparam int unsigned N  = 1600;
    localparam int unsigned CC = 320;
    localparam int unsigned OW = 11;
    localparam int unsigned W  = N / CC;

    logic clk;
    logic rst;

    hamming_stream_ctrl_if #(.W(W), .OW(OW)) bus ();

    hamming_stream_ctrl #(.N(N), .CC(CC), .OW(OW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator: stored sum plus popcount of the current chunk pair.
    logic [OW-1:0] acc_sum;
    assign bus.acc_o = acc_sum + OW'($countones(bus.x ^ bus.y));
    always @(posedge clk) begin
        if (bus.acc_clr) acc_sum <= '0;
        else             acc_sum <= bus.acc_o;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int beats = 0;
    int last_beat_edge = 0;
    logic rv_prev = 1'b0;
    logic [OW-1:0] sb[$];

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Edge counter and accepted-beat tracker.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && bus.in_valid && bus.in_ready) begin
            beats          <= beats + 1;
            last_beat_edge <= cyc + 1;
        end
    end

    // Result monitor: each rising result_valid pops one expected distance.
    always @(negedge clk) begin
        if (rst && bus.result_valid && !rv_prev) begin
            if (sb.size() == 0) begin
                chk_eq("unexpected_result", 1, 0);
            end else begin
                chk_eq("result", int'(bus.result), int'(sb.pop_front()));
                chk_eq("latency", cyc - last_beat_edge, 2);
            end
        end
        rv_prev = bus.result_valid;
    end

    task automatic run_stream(input logic [W-1:0] xv, input logic [W-1:0] yv,
                              input bit alt, input bit overrun, input bit hold_chk);
        int t;
        int base;
        logic [OW-1:0] exp_res;
        exp_res = OW'(CC * $countones(xv ^ yv));
        sb.push_back(exp_res);
        bus.result_ready = !hold_chk;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        base = beats;
        t = 0;
        while ((beats - base) < CC && t < 3 * CC) begin
            bus.in_valid = alt ? (t % 2 == 0) : 1'b1;
            bus.in_x     = xv;
            bus.in_y     = yv;
            @(negedge clk);
            t++;
        end
        chk_eq("stream_beats", beats - base, CC);
        if (overrun) begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                chk_eq("overrun_ready", int'(bus.in_ready), 0);
                @(negedge clk);
            end
            chk_eq("overrun_beats", beats - base, CC);
        end
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        if (hold_chk) begin
            t = 0;
            while (!bus.result_valid && t < 10) begin
                @(negedge clk);
                t++;
            end
            chk_eq("hold_valid_seen", int'(bus.result_valid), 1);
            for (int i = 0; i < 10; i++) begin
                bus.start = (i == 3);
                @(negedge clk);
                chk_eq("hold_result", int'(bus.result), int'(exp_res));
                chk_eq("hold_in_ready", int'(bus.in_ready), 0);
                chk_eq("hold_valid", int'(bus.result_valid), 1);
                chk_eq("hold_busy", int'(bus.busy), 1);
                chk_eq("hold_xy", int'(bus.x) + int'(bus.y), 0);
            end
            bus.start        = 1'b0;
            bus.result_ready = 1'b1;
            @(negedge clk);
            chk_eq("hold_release_busy", int'(bus.busy), 0);
            chk_eq("hold_release_valid", int'(bus.result_valid), 0);
        end
        t = 0;
        while (bus.busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk_eq("idle_return", int'(bus.busy), 0);
        chk_eq("sb_drained", sb.size(), 0);
        chk_eq("idle_acc_clr", int'(bus.acc_clr), 1);
        repeat (3) @(negedge clk);
        chk_eq("result_kept", int'(bus.result), int'(exp_res));
    endtask

    task automatic check_reset_vals(input string pfx);
        chk_eq({pfx, "_busy"},     int'(bus.busy), 0);
        chk_eq({pfx, "_in_ready"}, int'(bus.in_ready), 0);
        chk_eq({pfx, "_acc_clr"},  int'(bus.acc_clr), 1);
        chk_eq({pfx, "_rvalid"},   int'(bus.result_valid), 0);
        chk_eq({pfx, "_result"},   int'(bus.result), 0);
        chk_eq({pfx, "_xy"},       int'(bus.x) + int'(bus.y), 0);
    endtask

    initial begin
        int t;
        int base;
        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_x         = '0;
        bus.in_y         = '0;
        bus.result_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        // Equal operands, then beats offered past the end of the run.
        run_stream(5'h15, 5'h15, 1'b0, 1'b1, 1'b0);
        // All bits differ, result held with result_ready low.
        run_stream(5'h1F, 5'h00, 1'b0, 1'b0, 1'b1);
        // Alternate-cycle valid: one differing bit per beat.
        run_stream(5'h01, 5'h00, 1'b1, 1'b0, 1'b0);

        // Run abandoned by reset at beat 100.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        base         = beats;
        bus.in_valid = 1'b1;
        bus.in_x     = 5'h1F;
        bus.in_y     = 5'h00;
        t = 0;
        while ((beats - base) < 100 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk_eq("abort_beats", beats - base, 100);
        chk_eq("abort_busy_before", int'(bus.busy), 1);
        #2 rst = 1'b0;
        #1 check_reset_vals("abort");
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("abort_no_result", int'(bus.result_valid), 0);

        // Fresh run after the abort.
        run_stream(5'h03, 5'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
